// File: rtl/tract_m.sv
// ============================================================================
//  Module   : tract_m
//  Purpose  : M-stage data-memory access unit with req/rdy handshake, store
//             lane placement, load extraction and the M->W pipeline register.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tract_m (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ValidM,
  input  logic        RegWriteM,
  input  logic [4:0]  RdM,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [31:0] DMemAddr,
  output logic [3:0]  DMemBe,
  output logic [31:0] DMemWData,
  input  logic        DMemRdy,
  input  logic [31:0] DMemRData,
  output logic        StallM,
  output logic        MisalignM,
  output logic        RegWriteW1,
  output logic [4:0]  RdW1,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadPartDataW,
  output logic [31:0] PCPlus4W
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      r_state;

  // Request-side copies held for the whole handshake
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic        r_regwrite;
  logic [4:0]  r_rd;
  logic [1:0]  r_rsrc;
  logic [31:0] r_alu;
  logic [31:0] r_pc;

  logic        w_idle;
  logic        w_access;
  logic        w_misalign;
  logic        w_go;
  logic [1:0]  w_off;
  logic [1:0]  w_size;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_load;

  assign w_idle   = (r_state == S_IDLE);
  assign w_off    = ALUResultM[1:0];
  assign w_size   = Funct3M[1:0];
  assign w_access = ValidM & (MemWriteM | (ResultSrcM == 2'b01));

  // Size code 11 and the unsigned-word code 110 have no legal access form
  assign w_misalign = w_access & ((w_size == 2'b11) | (Funct3M == 3'b110) |
                                  ((w_size == 2'b01) & w_off[0]) |
                                  ((w_size == 2'b10) & (w_off != 2'b00)));
  assign w_go = w_access & ~w_misalign;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = WriteDataM;
    if (MemWriteM) begin
      case (w_size)
        2'b00: begin
          w_be    = 4'b0001 << w_off;
          w_wdata = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << w_off;
          w_wdata = {2{WriteDataM[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = WriteDataM;
        end
      endcase
    end
  end

  assign w_shifted = DMemRData >> {r_off, 3'b000};

  always_comb begin
    case (r_f3)
      3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_load = {24'd0, w_shifted[7:0]};
      3'b101:  w_load = {16'd0, w_shifted[15:0]};
      default: w_load = DMemRData;
    endcase
  end

  assign DMemReq   = reset_n & w_idle & w_go;
  assign StallM    = reset_n & (w_idle ? w_go : ~DMemRdy);
  assign MisalignM = reset_n & w_idle & w_misalign;
  assign DMemWe    = w_idle ? MemWriteM : r_we;
  assign DMemAddr  = w_idle ? {ALUResultM[31:2], 2'b00} : r_addr;
  assign DMemBe    = w_idle ? w_be : r_be;
  assign DMemWData = w_idle ? w_wdata : r_wdata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_we          <= 1'b0;
      r_addr        <= 32'd0;
      r_be          <= 4'd0;
      r_wdata       <= 32'd0;
      r_f3          <= 3'd0;
      r_off         <= 2'd0;
      r_regwrite    <= 1'b0;
      r_rd          <= 5'd0;
      r_rsrc        <= 2'd0;
      r_alu         <= 32'd0;
      r_pc          <= 32'd0;
      RegWriteW1    <= 1'b0;
      RdW1          <= 5'd0;
      ResultSrcW    <= 2'd0;
      ALUResultW    <= 32'd0;
      ReadPartDataW <= 32'd0;
      PCPlus4W      <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Only a valid non-memory instruction advances; everything else bubbles
          if (ValidM & ~w_access) begin
            RegWriteW1 <= RegWriteM;
            RdW1       <= RdM;
            ResultSrcW <= ResultSrcM;
            ALUResultW <= ALUResultM;
            PCPlus4W   <= PCPlus4M;
          end else begin
            RegWriteW1 <= 1'b0;
            RdW1       <= 5'd0;
            ResultSrcW <= 2'd0;
          end
          if (w_go) begin
            r_state    <= S_WAIT;
            r_we       <= MemWriteM;
            r_addr     <= {ALUResultM[31:2], 2'b00};
            r_be       <= w_be;
            r_wdata    <= w_wdata;
            r_f3       <= Funct3M;
            r_off      <= w_off;
            r_regwrite <= RegWriteM;
            r_rd       <= RdM;
            r_rsrc     <= ResultSrcM;
            r_alu      <= ALUResultM;
            r_pc       <= PCPlus4M;
          end
        end
        S_WAIT: begin
          if (DMemRdy) begin
            r_state       <= S_IDLE;
            RegWriteW1    <= r_regwrite & ~r_we;
            RdW1          <= r_rd;
            ResultSrcW    <= r_rsrc;
            ALUResultW    <= r_alu;
            PCPlus4W      <= r_pc;
            ReadPartDataW <= w_load;
          end else begin
            RegWriteW1 <= 1'b0;
            RdW1       <= 5'd0;
            ResultSrcW <= 2'd0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tract_m.sv
// ============================================================================
//  Module   : tb_tract_m
//  Purpose  : Self-checking bench for tract_m against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tract_m;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ValidM, RegWriteM, MemWriteM;
  logic [4:0]  RdM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic        DMemReq, DMemWe, DMemRdy;
  logic [31:0] DMemAddr, DMemWData, DMemRData;
  logic [3:0]  DMemBe;
  logic        StallM, MisalignM, RegWriteW1;
  logic [4:0]  RdW1;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW, ReadPartDataW, PCPlus4W;

  always #5 clk = ~clk;

  tract_m dut (
    .clk(clk), .reset_n(reset_n),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .RdM(RdM), .ResultSrcM(ResultSrcM),
    .MemWriteM(MemWriteM), .Funct3M(Funct3M), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr), .DMemBe(DMemBe),
    .DMemWData(DMemWData), .DMemRdy(DMemRdy), .DMemRData(DMemRData),
    .StallM(StallM), .MisalignM(MisalignM),
    .RegWriteW1(RegWriteW1), .RdW1(RdW1), .ResultSrcW(ResultSrcW),
    .ALUResultW(ALUResultW), .ReadPartDataW(ReadPartDataW), .PCPlus4W(PCPlus4W)
  );

  typedef struct {
    logic        req, stall, mis, chk_mem, chk_wd, we;
    logic [31:0] addr, wd;
    logic [3:0]  be;
  } comb_t;

  typedef struct {
    logic        rw, chk_data, chk_rpd;
    logic [4:0]  rd;
    logic [1:0]  rs;
    logic [31:0] alu, pc, rpd;
  } w_t;

  comb_t ec;
  w_t    ew;
  bit    chk_en = 0;
  int    checks = 0, errors = 0;
  int    req_cnt = 0, stall_cnt = 0, mis_cnt = 0;
  logic [3:0]  cap_be;
  logic [31:0] cap_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_mis(input logic [2:0] f3, input logic [1:0] off);
    if (f3 == 3'd3 || f3 >= 3'd6) return 1'b1;
    return (int'(off) % nbytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] off, input bit st);
    int mask;
    if (!st) return 4'hF;
    mask = (1 << nbytes(f3)) - 1;
    return 4'(mask << off);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (nbytes(f3))
      1:       return {24'd0, wd[7:0]} * 32'h0101_0101;
      2:       return {16'd0, wd[15:0]} * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rd);
    longint mask, v;
    int     n;
    n    = nbytes(f3);
    v    = longint'(rd >> (8 * int'(off)));
    mask = (64'd1 << (8 * n)) - 1;
    v    = v & mask;
    if (!f3[2] && n < 4 && v >= (mask + 1) / 2) v = v - (mask + 1);
    return v[31:0];
  endfunction

  function automatic comb_t zc();
    comb_t c;
    c = '{req: 0, stall: 0, mis: 0, chk_mem: 0, chk_wd: 0, we: 0, addr: 0, wd: 0, be: 0};
    return c;
  endfunction

  function automatic w_t bub();
    w_t w;
    w = '{rw: 0, chk_data: 0, chk_rpd: 0, rd: 0, rs: 0, alu: 0, pc: 0, rpd: 0};
    return w;
  endfunction

  function automatic w_t zeros();
    w_t w;
    w = bub();
    w.chk_data = 1;
    w.chk_rpd  = 1;
    return w;
  endfunction

  // ---------------- compare & capture ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("DMemReq", 32'(DMemReq), 32'(ec.req));
      chk("StallM", 32'(StallM), 32'(ec.stall));
      chk("MisalignM", 32'(MisalignM), 32'(ec.mis));
      if (ec.chk_mem) begin
        chk("DMemAddr", DMemAddr, ec.addr);
        chk("DMemWe", 32'(DMemWe), 32'(ec.we));
        chk("DMemBe", 32'(DMemBe), 32'(ec.be));
        if (ec.chk_wd) chk("DMemWData", DMemWData, ec.wd);
      end
      chk("RegWriteW1", 32'(RegWriteW1), 32'(ew.rw));
      chk("RdW1", 32'(RdW1), 32'(ew.rd));
      chk("ResultSrcW", 32'(ResultSrcW), 32'(ew.rs));
      if (ew.chk_data) begin
        chk("ALUResultW", ALUResultW, ew.alu);
        chk("PCPlus4W", PCPlus4W, ew.pc);
      end
      if (ew.chk_rpd) chk("ReadPartDataW", ReadPartDataW, ew.rpd);
    end
    if (DMemReq === 1'b1) begin
      req_cnt++;
      cap_be = DMemBe;
      cap_wd = DMemWData;
    end
    if (StallM === 1'b1) stall_cnt++;
    if (MisalignM === 1'b1) mis_cnt++;
  end

  task automatic tick(input w_t nxt);
    @(posedge clk);
    #1;
    ew = nxt;
  endtask

  task automatic clr();
    req_cnt = 0; stall_cnt = 0; mis_cnt = 0;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      reset_n = 0; ValidM = 0; DMemRdy = 1'($urandom);
      ec = zc();
      tick(zeros());
      chk_en = 1;
    end
    reset_n = 1;
  endtask

  // One instruction through M; delay = cycles from req to rdy
  task automatic run(input bit v, input bit rw, input logic [4:0] rd, input logic [1:0] rs,
                     input bit mw, input logic [2:0] f3, input logic [31:0] alu,
                     input logic [31:0] wd, input logic [31:0] pc, input int delay,
                     input logic [31:0] rdata, input bit rdy0);
    bit acc, mis;
    w_t n;
    acc = v && (mw || rs == 2'b01);
    mis = acc && m_mis(f3, alu[1:0]);
    ValidM = v; RegWriteM = rw; RdM = rd; ResultSrcM = rs; MemWriteM = mw;
    Funct3M = f3; ALUResultM = alu; WriteDataM = wd; PCPlus4M = pc;
    DMemRdy = rdy0; DMemRData = $urandom;
    ec = zc();
    if (!acc || mis) begin
      ec.mis = mis;
      n = bub();
      if (v && !acc) begin
        n = '{rw: rw, chk_data: 1, chk_rpd: 0, rd: rd, rs: rs, alu: alu, pc: pc, rpd: 0};
      end
      tick(n);
    end else begin
      ec.chk_mem = 1; ec.chk_wd = mw; ec.we = mw;
      ec.addr = {alu[31:2], 2'b00};
      ec.be = m_be(f3, alu[1:0], mw);
      ec.wd = m_wdata(f3, wd);
      for (int k = 0; k < delay; k++) begin
        ec.req = (k == 0); ec.stall = 1;
        if (k > 0) begin DMemRdy = 0; DMemRData = $urandom; end
        tick(bub());
      end
      ec.req = 0; ec.stall = 0;
      DMemRdy = 1; DMemRData = rdata;
      n = '{rw: rw && !mw, chk_data: 1, chk_rpd: !mw, rd: rd, rs: rs, alu: alu, pc: pc,
            rpd: m_load(f3, alu[1:0], rdata)};
      tick(n);
    end
    DMemRdy = 0;
  endtask

  initial begin
    logic [2:0] lf3 [5];
    int kind;
    lf3[0] = 3'b000; lf3[1] = 3'b001; lf3[2] = 3'b010; lf3[3] = 3'b100; lf3[4] = 3'b101;
    reset_n = 0; ValidM = 0; RegWriteM = 0; RdM = 0; ResultSrcM = 0; MemWriteM = 0;
    Funct3M = 0; ALUResultM = 0; WriteDataM = 0; PCPlus4M = 0; DMemRdy = 0; DMemRData = 0;
    ec = zc(); ew = zeros();
    do_reset(2);

    // LW aligned, minimum latency
    clr();
    run(1, 1, 5'd3, 2'b01, 0, 3'b010, 32'h100, 32'h0, 32'h104, 1, 32'hDEADBEEF, 0);
    chk("lw_req_cycles", 32'(req_cnt), 32'd1);
    chk("lw_stall_cycles", 32'(stall_cnt), 32'd1);
    chk("lw_data", ReadPartDataW, 32'hDEADBEEF);
    chk("lw_regwrite", 32'(RegWriteW1), 32'd1);

    // LB / LBU on the top byte
    run(1, 1, 5'd4, 2'b01, 0, 3'b000, 32'h103, 32'h0, 32'h108, 1, 32'h80FF_0000, 0);
    chk("lb_data", ReadPartDataW, 32'hFFFFFF80);
    run(1, 1, 5'd5, 2'b01, 0, 3'b100, 32'h103, 32'h0, 32'h10C, 2, 32'h80FF_0000, 1);
    chk("lbu_data", ReadPartDataW, 32'h00000080);

    // SH upper half
    clr();
    run(1, 1, 5'd6, 2'b00, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'h110, 1, 32'h0, 0);
    chk("sh_be", 32'(cap_be), 32'h0000000C);
    chk("sh_wdata", cap_wd, 32'hABCDABCD);
    chk("sh_regwrite", 32'(RegWriteW1), 32'd0);

    // Misaligned LW
    clr();
    run(1, 1, 5'd7, 2'b01, 0, 3'b010, 32'h101, 32'h0, 32'h114, 1, 32'h0, 0);
    chk("mis_req", 32'(req_cnt), 32'd0);
    chk("mis_pulse", 32'(mis_cnt), 32'd1);
    chk("mis_stall", 32'(stall_cnt), 32'd0);
    chk("mis_regwrite", 32'(RegWriteW1), 32'd0);

    // Rdy pulse in IDLE before the request, then a slow response
    run(0, 0, 5'd0, 2'b00, 0, 3'b000, 32'h0, 32'h0, 32'h0, 1, 32'h0, 1);
    clr();
    run(1, 1, 5'd8, 2'b01, 0, 3'b010, 32'h200, 32'h0, 32'h118, 6, 32'h5555AAAA, 1);
    chk("slow_stall_cycles", 32'(stall_cnt), 32'd6);
    chk("slow_req_cycles", 32'(req_cnt), 32'd1);
    chk("slow_data", ReadPartDataW, 32'h5555AAAA);

    // Reset while waiting; the late Rdy must not update W
    ValidM = 1; RegWriteM = 1; RdM = 5'd9; ResultSrcM = 2'b01; MemWriteM = 0;
    Funct3M = 3'b010; ALUResultM = 32'h300; PCPlus4M = 32'h11C; DMemRdy = 0;
    ec = zc(); ec.req = 1; ec.stall = 1; ec.chk_mem = 1; ec.addr = 32'h300; ec.be = 4'hF;
    tick(bub());
    ec.req = 0;
    tick(bub());
    reset_n = 0; ValidM = 0; ec = zc();
    tick(zeros());
    reset_n = 1; DMemRdy = 1; DMemRData = 32'hFFFF_FFFF;
    clr();
    tick(zeros());
    DMemRdy = 0;
    chk("rst_wait_stall", 32'(stall_cnt), 32'd0);
    chk("rst_wait_rpd", ReadPartDataW, 32'd0);
    chk("rst_wait_rd", 32'(RdW1), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [2:0] f3;
      logic [1:0] rs;
      kind = $urandom_range(0, 9);
      f3 = lf3[$urandom_range(0, 4)];
      case (kind)
        0: run(0, 1'($urandom), 5'($urandom), 2'($urandom), 1'($urandom), 3'($urandom),
               $urandom, $urandom, $urandom, 1, 0, 1'($urandom));
        1, 2, 3: begin
          rs = 2'($urandom);
          if (rs == 2'b01) rs = 2'b00;
          run(1, 1'($urandom), 5'($urandom), rs, 0, 3'($urandom), $urandom, $urandom,
              $urandom, 1, 0, 1'($urandom));
        end
        4, 5, 6: run(1, 1'($urandom), 5'($urandom), 2'b01, 0, f3, $urandom, $urandom,
                     $urandom, $urandom_range(1, 4), $urandom, 1'($urandom));
        7, 8: run(1, 1'($urandom), 5'($urandom), 2'b00, 1, 3'($urandom_range(0, 3)),
                  $urandom, $urandom, $urandom, $urandom_range(1, 4), $urandom, 1'($urandom));
        default: run(1, 1, 5'($urandom), 2'b01, 0, 3'($urandom), $urandom, $urandom,
                     $urandom, $urandom_range(1, 3), $urandom, 1'($urandom));
      endcase
      if (i == 200) do_reset(1);
    end

    ValidM = 0;
    ec = zc();
    tick(bub());
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
